// File: rtl/cart_upload_server.sv
// -----------------------------------------------------------------------------
// cart_upload_server
//
// Answers HPS upload (core-to-HPS readback) byte requests for the cartridge/RAM
// image. Each ioctl_rd for this image's index and an in-range address becomes
// one read of a core-side memory with a fixed read latency. ioctl_wait is held
// until the byte is on ioctl_din. Out-of-range requests get a fill byte.
// Requests for another index, or outside a session, get 8'h00. Both of these
// are answered at once. The block also counts served bytes and flags requests
// that arrive while a read is still in flight.
//
// Parameters:
//   INDEX   ioctl_index value answered by this block
//   SIZE    image length in bytes (valid addresses 0..SIZE-1)
//   RD_LAT  memory read latency in cycles, 1..3
//   FILL    byte returned for addresses at or beyond SIZE
//
// Ports:
//   clk_sys        in   system clock
//   reset_n        in   asynchronous active-low reset
//   ioctl_upload   in   upload session active (level)
//   ioctl_index    in   image index of the session
//   ioctl_rd       in   one-cycle byte request
//   ioctl_addr     in   byte address, valid with ioctl_rd
//   ioctl_din      out  returned byte
//   ioctl_wait     out  request in progress, HPS must hold off
//   mem_rd         out  one-cycle memory read strobe
//   mem_addr       out  memory address, held until the next accepted request
//   mem_dout       in   memory data, valid RD_LAT cycles after mem_rd
//   upload_active  out  registered (ioctl_upload && index match)
//   bytes_served   out  requests completed this session (saturating)
//   overrun        out  sticky, ioctl_rd seen while busy
// -----------------------------------------------------------------------------
module cart_upload_server #(
  parameter logic [7:0]  INDEX  = 8'h01,
  parameter logic [24:0] SIZE   = 25'h10000,
  parameter int          RD_LAT = 2,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_rd,
  output logic [24:0] mem_addr,
  input  logic [7:0]  mem_dout,
  output logic        upload_active,
  output logic [24:0] bytes_served,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LAT   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Cycles spent in LAT = RD_LAT-1. DONE is the cycle in which mem_dout is
  // valid, so with RD_LAT=1 the FSM goes straight from ISSUE to DONE.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  din_q, din_d;
  logic        mem_rd_q, mem_rd_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic        up_act_q, up_act_d;
  logic [24:0] bytes_q, bytes_d;
  logic        overrun_q, overrun_d;
  logic        upload_prev_q, upload_prev_d;

  logic        session_edge;
  logic        idx_match;
  logic        in_range;
  logic        accept;

  function automatic logic [24:0] sat_inc(input logic [24:0] v);
    return (v == '1) ? v : v + 25'd1;
  endfunction

  always_comb begin
    session_edge  = ioctl_upload & ~upload_prev_q;
    idx_match     = (ioctl_index == INDEX);
    in_range      = (ioctl_addr < SIZE);
    accept        = (state_q == IDLE) & ioctl_rd & ioctl_upload & idx_match & in_range;

    state_d       = state_q;
    cnt_d         = cnt_q;
    din_d         = din_q;
    mem_rd_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    up_act_d      = ioctl_upload & idx_match;
    upload_prev_d = ioctl_upload;
    // A new session clears the statistics; a request in the same cycle is
    // then counted on top of the cleared value.
    bytes_d       = session_edge ? '0 : bytes_q;
    overrun_d     = session_edge ? 1'b0 : overrun_q;

    case (state_q)
      IDLE: begin
        if (ioctl_rd) begin
          if (accept) begin
            // mem_rd is registered, so it is high during the ISSUE cycle.
            mem_addr_d = ioctl_addr;
            mem_rd_d   = 1'b1;
            state_d    = ISSUE;
          end else if (ioctl_upload && idx_match) begin
            din_d   = FILL;
            bytes_d = sat_inc(bytes_d);
          end else begin
            din_d = 8'h00;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = (LAT_LOAD == 2'd0) ? DONE : LAT;
      end
      LAT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) state_d = DONE;
      end
      DONE: begin
        din_d   = mem_dout;
        bytes_d = sat_inc(bytes_d);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (ioctl_rd && !session_edge) overrun_d = 1'b1;
      // Session dropped mid-read: abandon it without touching the result.
      if (!ioctl_upload) begin
        state_d = IDLE;
        din_d   = din_q;
        bytes_d = bytes_q;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      din_q         <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      up_act_q      <= 1'b0;
      bytes_q       <= '0;
      overrun_q     <= 1'b0;
      upload_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      din_q         <= din_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      up_act_q      <= up_act_d;
      bytes_q       <= bytes_d;
      overrun_q     <= overrun_d;
      upload_prev_q <= upload_prev_d;
    end
  end

  // ioctl_wait rises in the request cycle itself, before any state change.
  assign ioctl_wait    = accept | (state_q != IDLE);
  assign ioctl_din     = din_q;
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign upload_active = up_act_q;
  assign bytes_served  = bytes_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_cart_upload_server.sv
// -----------------------------------------------------------------------------
// tb_cart_upload_server
//
// Three instances of cart_upload_server with RD_LAT = 1, 2, 3, each with its
// own memory model that presents valid data only in the cycle exactly RD_LAT
// cycles after mem_rd. A per-instance reference model predicts the response to
// each request (byte, busy length, read strobes, byte count, overrun) from the
// request and session state alone.
// -----------------------------------------------------------------------------
module tb_cart_upload_server;

  localparam logic [7:0]  INDEX_C = 8'h01;
  localparam logic [24:0] SIZE_C  = 25'h10000;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        up    [3];
  logic [7:0]  ix    [3];
  logic        rd    [3];
  logic [24:0] ad    [3];
  logic [7:0]  din   [3];
  logic        wt    [3];
  logic        mrd   [3];
  logic [24:0] maddr [3];
  logic        uact  [3];
  logic [24:0] bsv   [3];
  logic        ovr   [3];

  int          exp_cnt [3];
  logic        exp_ovr [3];
  logic [7:0]  exp_din [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Image contents: a fixed marker at 0x10 and a scrambled pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    logic [7:0] t;
    if (a == 25'h10) return 8'hA5;
    t = a[7:0] * 8'd29;
    return t ^ a[15:8] ^ 8'h6B;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [2:0]  pv = '0;
    logic [24:0] pa [3];
    logic [7:0]  mdout;

    always @(posedge clk) begin
      pv    <= {pv[1:0], mrd[g]};
      pa[0] <= maddr[g];
      pa[1] <= pa[0];
      pa[2] <= pa[1];
    end

    // Outside the valid cycle the bus carries the complement of the byte.
    assign mdout = pv[g] ? mem_byte(pa[g]) : ~mem_byte(maddr[g]);

    cart_upload_server #(.RD_LAT(g + 1)) u_dut (
      .clk_sys      (clk),
      .reset_n      (rst_n),
      .ioctl_upload (up[g]),
      .ioctl_index  (ix[g]),
      .ioctl_rd     (rd[g]),
      .ioctl_addr   (ad[g]),
      .ioctl_din    (din[g]),
      .ioctl_wait   (wt[g]),
      .mem_rd       (mrd[g]),
      .mem_addr     (maddr[g]),
      .mem_dout     (mdout),
      .upload_active(uact[g]),
      .bytes_served (bsv[g]),
      .overrun      (ovr[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upload(input int i, input logic v);
    if (v && !up[i]) begin
      exp_cnt[i] = 0;
      exp_ovr[i] = 1'b0;
    end
    up[i] = v;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      exp_cnt[i] = 0;
      exp_ovr[i] = 1'b0;
      exp_din[i] = 8'h00;
    end
  endtask

  // One request on instance i, checked against the model.
  task automatic serve(input int i, input logic [24:0] a);
    int          busy, nrd, want_busy, want_nrd;
    logic [7:0]  want;
    logic [24:0] maddr_t1;
    logic        match;
    match = up[i] && (ix[i] == INDEX_C);
    if (!match) begin
      want = 8'h00; want_busy = 0; want_nrd = 0;
    end else if (a >= SIZE_C) begin
      want = 8'hFF; want_busy = 0; want_nrd = 0; exp_cnt[i]++;
    end else begin
      want = mem_byte(a); want_busy = i + 3; want_nrd = 1; exp_cnt[i]++;
    end
    ad[i] = a;
    rd[i] = 1'b1;
    #1;
    busy = wt[i] ? 1 : 0;
    @(posedge clk);
    #1;
    rd[i] = 1'b0;
    #1;
    nrd      = mrd[i] ? 1 : 0;
    maddr_t1 = maddr[i];
    while (wt[i] && busy < 12) begin
      busy++;
      tick();
      if (mrd[i]) nrd++;
    end
    exp_din[i] = want;
    check_eq($sformatf("L%0d a=%0h wait_cycles", i + 1, a), busy, want_busy);
    check_eq($sformatf("L%0d a=%0h mem_rd_count", i + 1, a), nrd, want_nrd);
    if (want_nrd == 1) check_eq($sformatf("L%0d a=%0h mem_addr", i + 1, a), maddr_t1, a);
    check_eq($sformatf("L%0d a=%0h din", i + 1, a), din[i], want);
    check_eq($sformatf("L%0d a=%0h bytes_served", i + 1, a), bsv[i], exp_cnt[i]);
    check_eq($sformatf("L%0d a=%0h overrun", i + 1, a), ovr[i], exp_ovr[i]);
    check_eq($sformatf("L%0d a=%0h upload_active", i + 1, a), uact[i], match);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nrd, cnt, r;
    logic [24:0] a;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up[i] = 1'b0; ix[i] = INDEX_C; rd[i] = 1'b0; ad[i] = '0;
    end
    reset_model();
    tick();
    tick();

    // Reset state
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("L%0d reset din", i + 1), din[i], 0);
      check_eq($sformatf("L%0d reset wait", i + 1), wt[i], 0);
      check_eq($sformatf("L%0d reset mem_rd", i + 1), mrd[i], 0);
      check_eq($sformatf("L%0d reset mem_addr", i + 1), maddr[i], 0);
      check_eq($sformatf("L%0d reset upload_active", i + 1), uact[i], 0);
      check_eq($sformatf("L%0d reset bytes_served", i + 1), bsv[i], 0);
      check_eq($sformatf("L%0d reset overrun", i + 1), ovr[i], 0);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) set_upload(i, 1'b1);
    tick();
    check_eq("L2 upload_active lag", uact[1], 1);

    // Basic read, out of range, foreign index on RD_LAT=2
    serve(1, 25'h10);
    serve(1, SIZE_C);
    serve(1, SIZE_C + 25'd5);
    serve(1, SIZE_C - 25'd1);
    ix[1] = 8'h02;
    serve(1, 25'h0);
    ix[1] = INDEX_C;
    tick();

    // Overrun: second request one cycle into a busy read
    ad[1] = 25'h20; rd[1] = 1'b1;
    tick();
    ad[1] = 25'h30; rd[1] = 1'b1;
    #1;
    check_eq("ovr mem_rd at T+1", mrd[1], 1);
    check_eq("ovr mem_addr at T+1", maddr[1], 25'h20);
    nrd = 1;
    tick();
    rd[1] = 1'b0;
    cnt = 0;
    while (wt[1] && cnt < 12) begin
      tick();
      cnt++;
      if (mrd[1]) nrd++;
    end
    exp_cnt[1]++;
    exp_ovr[1] = 1'b1;
    exp_din[1] = mem_byte(25'h20);
    check_eq("ovr din", din[1], exp_din[1]);
    check_eq("ovr mem_rd_count", nrd, 1);
    check_eq("ovr flag", ovr[1], 1);
    check_eq("ovr bytes_served", bsv[1], exp_cnt[1]);
    serve(1, 25'h33);

    // Abort on RD_LAT=3: upload drops at T+2
    serve(2, 25'h55);
    ad[2] = 25'h40; rd[2] = 1'b1;
    tick();
    rd[2] = 1'b0;
    tick();
    set_upload(2, 1'b0);
    #1;
    check_eq("abort wait at T+2", wt[2], 1);
    tick();
    check_eq("abort wait at T+3", wt[2], 0);
    check_eq("abort din kept", din[2], exp_din[2]);
    check_eq("abort bytes_served", bsv[2], exp_cnt[2]);
    check_eq("abort mem_rd", mrd[2], 0);
    tick();
    check_eq("abort din still kept", din[2], exp_din[2]);
    set_upload(2, 1'b1);
    tick();
    check_eq("abort new session count", bsv[2], 0);

    // Session edge coincident with a request: counts as 1
    set_upload(0, 1'b0);
    tick();
    set_upload(0, 1'b1);
    serve(0, SIZE_C + 25'd1);
    set_upload(1, 1'b0);
    tick();
    set_upload(1, 1'b1);
    serve(1, 25'h10);

    // Reset in the middle of a read
    ad[1] = 25'h50; rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;
    #1;
    check_eq("midreset mem_rd before", mrd[1], 1);
    rst_n = 1'b0;
    #1;
    check_eq("midreset mem_rd", mrd[1], 0);
    check_eq("midreset wait", wt[1], 0);
    check_eq("midreset din", din[1], 0);
    check_eq("midreset mem_addr", maddr[1], 0);
    check_eq("midreset bytes_served", bsv[1], 0);
    check_eq("midreset upload_active", uact[1], 0);
    reset_model();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Randomized requests on every latency
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 60; k++) begin
        r = $urandom_range(0, 99);
        if (r < 6)       set_upload(i, 1'b0);
        else if (r < 20) set_upload(i, 1'b1);
        ix[i] = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(2, 255)) : INDEX_C;
        case ($urandom_range(0, 5))
          0:       a = 25'h0;
          1:       a = SIZE_C - 25'd1;
          2:       a = SIZE_C;
          3:       a = SIZE_C + 25'($urandom_range(1, 1000));
          default: a = 25'($urandom_range(0, 32'hFFFF));
        endcase
        serve(i, a);
      end
      set_upload(i, 1'b1);
      ix[i] = INDEX_C;
    end

    // Latency sweep: 256 sequential bytes on RD_LAT=1 and RD_LAT=3
    for (int s = 0; s < 2; s++) begin
      int i;
      i = (s == 0) ? 0 : 2;
      set_upload(i, 1'b0);
      tick();
      set_upload(i, 1'b1);
      tick();
      for (int k = 0; k < 256; k++) serve(i, 25'(k + 25'h100));
      check_eq($sformatf("L%0d sweep total", i + 1), bsv[i], 256);
      set_upload(i, 1'b0);
      tick();
      set_upload(i, 1'b1);
      tick();
      check_eq($sformatf("L%0d sweep new session", i + 1), bsv[i], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
